// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: loads a pattern, arms on start, counts
// matches on the qualified bit stream and stops in DONE when the target is hit.
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic             detected,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pattern_r, pattern_n;
  logic             overlap_r, overlap_n;
  logic [CNT_W-1:0] target_r, target_n;
  logic [PAT_W-1:0] history, history_n;
  logic [FW-1:0]    fill, fill_n;
  logic [CNT_W-1:0] match_cnt_n;
  logic             detected_n, cfg_err_n;

  logic [PAT_W-1:0] hist_shift;
  logic [FW-1:0]    fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_hit;

  // The fill count masks stale history so a match needs PAT_W fresh bits.
  assign hist_shift = {history[PAT_W-2:0], din};
  assign fill_inc   = (fill == FILL_MAX) ? fill : fill + 1'b1;
  assign cnt_inc    = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
  assign match_hit  = (hist_shift == pattern_r) && (fill_inc == FILL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pattern_r <= '0;
      overlap_r <= 1'b1;
      target_r  <= '0;
      history   <= '0;
      fill      <= '0;
      match_cnt <= '0;
      detected  <= 1'b0;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      pattern_r <= pattern_n;
      overlap_r <= overlap_n;
      target_r  <= target_n;
      history   <= history_n;
      fill      <= fill_n;
      match_cnt <= match_cnt_n;
      detected  <= detected_n;
      cfg_err   <= cfg_err_n;
      busy      <= (state_n == ARMED);
      done      <= (state_n == DONE);
    end
  end

  // Priority: abort, then start, then serial data; config is independent.
  always_comb begin
    state_n     = state;
    pattern_n   = pattern_r;
    overlap_n   = overlap_r;
    target_n    = target_r;
    history_n   = history;
    fill_n      = fill;
    match_cnt_n = match_cnt;
    detected_n  = 1'b0;
    cfg_err_n   = 1'b0;

    if (cfg_we) begin
      if (state == IDLE) begin
        pattern_n = cfg_pattern;
        overlap_n = cfg_overlap;
        target_n  = cfg_target;
      end else begin
        cfg_err_n = 1'b1;
      end
    end

    if (abort) begin
      state_n = IDLE;
    end else if (start && (state != ARMED)) begin
      state_n     = ARMED;
      history_n   = '0;
      fill_n      = '0;
      match_cnt_n = '0;
    end else if ((state == ARMED) && din_valid) begin
      history_n = hist_shift;
      fill_n    = fill_inc;
      if (match_hit) begin
        detected_n  = 1'b1;
        match_cnt_n = cnt_inc;
        if (!overlap_r)
          fill_n = '0;
        if ((target_r != '0) && (cnt_inc == target_r))
          state_n = DONE;
      end
    end
  end

endmodule
